// File: rtl/rtc_bus_writer_if.sv
// rtc_bus_writer_if: request side and multiplexed A/D bus pins
// of the RTC write-cycle master.
interface rtc_bus_writer_if;
    logic       start;
    logic [7:0] addr;
    logic [7:0] data;
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_n;
    logic       ad_oe;
    logic [7:0] ad_out;

    modport master (
        input  start, addr, data,
        output busy, done, cs_n, rd_n,
        output wr_n, ad_n, ad_oe, ad_out
    );

    modport slave (
        output start, addr, data,
        input  busy, done, cs_n, rd_n,
        input  wr_n, ad_n, ad_oe, ad_out
    );
endinterface

// File: rtl/rtc_bus_writer.sv
// rtc_bus_writer: drives one two-phase (address then data) write
// cycle on the multiplexed RTC bus; all outputs registered.
module rtc_bus_writer #(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2
) (
    input logic           clk,
    input logic           reset,
    rtc_bus_writer_if.master bus
);
    localparam int S = (T_SETUP < 1) ? 1 : T_SETUP;
    localparam int P = (T_PULSE < 1) ? 1 : T_PULSE;
    localparam int H = (T_HOLD  < 1) ? 1 : T_HOLD;
    localparam int M1 = (S > P) ? S : P;
    localparam int MAXD = (M1 > H) ? M1 : H;
    localparam int CW = (MAXD > 1) ? $clog2(MAXD) : 1;

    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t LS = cnt_t'(S - 1);
    localparam cnt_t LP = cnt_t'(P - 1);
    localparam cnt_t LH = cnt_t'(H - 1);

    typedef enum logic [2:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD,
        D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [7:0] a_q, a_d;
    logic [7:0] d_q, d_d;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       cs_q, cs_d;
    logic       wr_q, wr_d;
    logic       adn_q, adn_d;
    logic       oe_q, oe_d;
    logic [7:0] out_q, out_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            adn_q   <= 1'b1;
            oe_q    <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            adn_q   <= adn_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
        end
    end

    // timed states count down; each transition reloads the next duration
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        cnt_d   = (cnt_q == '0) ? '0 : cnt_q - cnt_t'(1);
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = A_SETUP;
                    cnt_d   = LS;
                    a_d     = bus.addr;
                    d_d     = bus.data;
                end
            end
            A_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = A_STROBE;
                    cnt_d   = LP;
                end
            end
            A_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = A_HOLD;
                    cnt_d   = LH;
                end
            end
            A_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = D_SETUP;
                    cnt_d   = LS;
                end
            end
            D_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = D_STROBE;
                    cnt_d   = LP;
                end
            end
            D_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = D_HOLD;
                    cnt_d   = LH;
                end
            end
            D_HOLD: begin
                if (cnt_q == '0) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs decoded from the upcoming state so they register with it
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = 1'b0;
        cs_d   = 1'b1;
        wr_d   = 1'b1;
        adn_d  = 1'b1;
        oe_d   = 1'b0;
        out_d  = '0;
        unique case (state_d)
            A_SETUP, A_STROBE, A_HOLD: begin
                cs_d  = 1'b0;
                oe_d  = 1'b1;
                adn_d = 1'b0;
                out_d = a_d;
                wr_d  = (state_d != A_STROBE);
            end
            D_SETUP, D_STROBE, D_HOLD: begin
                cs_d  = 1'b0;
                oe_d  = 1'b1;
                out_d = d_d;
                wr_d  = (state_d != D_STROBE);
            end
            DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.cs_n   = cs_q;
    assign bus.rd_n   = 1'b1;
    assign bus.wr_n   = wr_q;
    assign bus.ad_n   = adn_q;
    assign bus.ad_oe  = oe_q;
    assign bus.ad_out = out_q;
endmodule

// File: doc/rtc_bus_writer.md
# rtc_bus_writer

Write-cycle master for the multiplexed address/data RTC bus: takes an 8-bit register address and an 8-bit value, and drives one complete two-phase bus write. The address phase is strobed with the A/D select low, and the data phase with A/D high. It is the transmit counterpart of the segment/time capture registers that latch bytes read back from the same bus. It sits between the time-set control FSM and the RTC pin tri-state buffers.

## Interface
Parameters:
- T_SETUP, 2, cycles the address or data is driven before `wr_n` falls (values below 1 are treated as 1)
- T_PULSE, 4, cycles `wr_n` is held low in each phase (values below 1 are treated as 1)
- T_HOLD, 2, cycles the address or data is held after `wr_n` rises (values below 1 are treated as 1)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high; forces the idle state immediately
- start  in  1  single-cycle request; sampled only in IDLE
- addr  in  8  RTC register address; captured on the accepted `start`
- data  in  8  byte to write; captured on the accepted `start`
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse marking completion of the transaction
- cs_n  out  1  chip select, active low
- rd_n  out  1  read strobe; held high at all times (write-only block)
- wr_n  out  1  write strobe, active low
- ad_n  out  1  A/D select: 0 = address phase, 1 = data phase
- ad_oe  out  1  tri-state enable for the shared bus; 1 = drive `ad_out`
- ad_out  out  8  value driven onto the bus

## Operation
- Every output is registered (Moore) and decoded from the state plus the captured bytes.
- Reset and idle values: cs_n=1, rd_n=1, wr_n=1, ad_n=1, ad_oe=0, ad_out=8'h00, busy=0, done=0.
- States and sequence: IDLE → A_SETUP → A_STROBE → A_HOLD → D_SETUP → D_STROBE → D_HOLD → DONE → IDLE.
- IDLE: if `start`=1, capture `addr` and `data` into internal registers and go to A_SETUP. Otherwise remain in IDLE.
- A_SETUP: cs_n=0, ad_oe=1, ad_n=0, ad_out=captured addr, wr_n=1.
- A_STROBE: same as A_SETUP but wr_n=0.
- A_HOLD: same as A_SETUP (wr_n=1).
- D_SETUP: cs_n=0, ad_oe=1, ad_n=1, ad_out=captured data, wr_n=1.
- D_STROBE: same as D_SETUP but wr_n=0.
- D_HOLD: same as D_SETUP (wr_n=1).
- DONE, one cycle: done=1, busy=1, cs_n=1, ad_oe=0, ad_out=8'h00.
- Phase durations come from one down-counter. It is loaded with (duration−1) on entry to each timed state, and the state advances when the counter reads 0.
- `start` is ignored in every state except IDLE. Captured bytes do not change mid-transaction, even if `addr`/`data` change.
- `start` asserted in the same cycle that DONE returns to IDLE is not accepted. A new request is accepted in IDLE on the following cycle at the earliest.
- Reset asserted mid-transaction: all outputs return to their idle values asynchronously, the counter clears, and the captured bytes clear to 0. No `done` pulse is produced.

## Timing
- `start` sampled at edge k: outputs show A_SETUP values after edge k. busy=1 from edge k.
- `wr_n` low windows: the address strobe spans edges k+S to k+S+P. The data strobe begins at edge k+2S+P+H.
- DONE is entered at edge k+2(S+P+H). IDLE is entered at edge k+2(S+P+H)+1.
- Total busy length: 2(S+P+H)+1 cycles. With the defaults this is 17 cycles.
- The A/D select transitions only while wr_n=1. `ad_out` changes only at phase boundaries or in IDLE/DONE.
- Back-to-back transactions: minimum start-to-start spacing is 2(S+P+H)+2 cycles.

## Test plan
- Reset values: assert reset asynchronously between clock edges. Outputs must take idle values immediately: cs_n=1, wr_n=1, ad_oe=0, ad_out=00, busy=0, done=0.
- Single write (defaults): addr=8'h21, data=8'h59, one-cycle start.
  - ad_n=0, ad_out=21 for 8 cycles, with wr_n low for cycles 3–6.
  - Then ad_n=1, ad_out=59 for 8 cycles, with wr_n low for cycles 11–14.
  - done=1 in cycle 17; busy high for exactly 17 cycles; rd_n=1 throughout.
- Input stability: change addr/data and pulse start during D_STROBE. Bus values stay 21/59, the extra start is ignored, and exactly one done pulse occurs.
- Reset mid-operation: assert reset during A_STROBE. Bus is released at once with no done pulse. A following start with addr=8'h00, data=8'h12 completes normally.
- Parameter override: T_SETUP=1, T_PULSE=1, T_HOLD=1. Total busy length is 7 cycles, with a single-cycle wr_n low pulse in each phase.
- Back-to-back: hold start=1 continuously. Transactions repeat with a start-to-start spacing of 18 cycles (defaults), and there is one idle cycle with cs_n=1 between them.
